lsl16bit_seq: RTL

- Multi-cycle logical shift-left unit for the ALU shifter group.
- Complements the existing right-shift path, which is single-cycle and sign-aware.
- Shifts a 16-bit operand left by 0..15 positions, one bit per clock.
- Uses a start/busy/done handshake and reports carry-out and signed-overflow flags for the status register.

---
 rtl/alu_pkg.sv | 17 +
 rtl/lsl16bit_seq.sv | 94 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, shifter FSM states, status-word flag positions.
// Pure declarations; no logic, no latency, no flow control.
package alu_pkg;

   localparam int ALU_WIDTH   = 16;
   localparam int SHIFT_AMT_W = 4;

   // Bit positions of carry and signed-overflow in the ALU status word.
   localparam int FLAG_C_IDX = 0;
   localparam int FLAG_V_IDX = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } shft_state_t;

endpackage

// File: rtl/lsl16bit_seq.sv
// Multi-cycle logical shift-left, one bit per clock, with carry-out and signed-overflow flags.
// Latency: done N+1 cycles after start is sampled (N = shift amount, 0..15); N=0 completes next cycle.
// Backpressure: start is ignored while busy; a new start is accepted in the done cycle.
module lsl16bit_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SHW   = SHIFT_AMT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] inp,
   input  logic [15:0]      shift_value,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow
);

   shft_state_t      state, state_nxt;
   logic [WIDTH-1:0] acc;
   logic [SHW-1:0]   cnt;
   logic             ovf_sticky;
   logic [SHW-1:0]   shamt;
   logic             step_ovf;
   logic             unused_shift_hi;

   assign shamt           = shift_value[SHW-1:0];
   assign unused_shift_hi = ^shift_value[15:SHW];
   // A shift changes the sign whenever the top two bits differ before it.
   assign step_ovf        = acc[WIDTH-1] ^ acc[WIDTH-2];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && (shamt != '0)) state_nxt = SHIFT;
         SHIFT:   if (cnt == SHW'(1))         state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         out        <= '0;
         carry_out  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc        <= inp;
                  cnt        <= shamt;
                  ovf_sticky <= 1'b0;
                  if (shamt == '0) begin
                     out       <= inp;
                     carry_out <= 1'b0;
                     overflow  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     busy <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               acc        <= {acc[WIDTH-2:0], 1'b0};
               ovf_sticky <= ovf_sticky | step_ovf;
               cnt        <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  out       <= {acc[WIDTH-2:0], 1'b0};
                  carry_out <= acc[WIDTH-1];
                  overflow  <= ovf_sticky | step_ovf;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
